// File: rtl/t07_pkg.sv
// Shared types and constants for the team_07 bomb game controllers.
package t07_pkg;

  typedef logic [2:0] game_state_t;
  localparam game_state_t MENU = 3'd0;
  localparam game_state_t PLAY = 3'd1;
  localparam game_state_t LOST = 3'd2;
  localparam game_state_t WON  = 3'd3;

  typedef logic [2:0] playing_state_t;
  localparam playing_state_t PS_IDLE   = 3'd0;
  localparam playing_state_t PS_SELECT = 3'd1;
  localparam playing_state_t PS_MODULE = 3'd2;
  localparam playing_state_t PS_DONE   = 3'd3;

  localparam logic [5:0] BTN_NONE   = 6'b000000;
  localparam logic [5:0] BTN_SELECT = 6'b000001;
  localparam logic [5:0] BTN_UP     = 6'b000010;
  localparam logic [5:0] BTN_RIGHT  = 6'b000100;
  localparam logic [5:0] BTN_DOWN   = 6'b001000;
  localparam logic [5:0] BTN_LEFT   = 6'b010000;
  localparam logic [5:0] BTN_BACK   = 6'b100000;

  // Every one-hot 6-bit value is a defined button code, so a press is strobe plus one-hot.
  function automatic logic is_press(input logic strobe, input logic [5:0] button);
    return strobe && $onehot(button);
  endfunction

endpackage

// File: rtl/t07_sec_prescaler.sv
// Divides the system clock down to a one-cycle tick every CLK_HZ cycles while enabled.
module t07_sec_prescaler #(
  parameter int CLK_HZ = 12_000_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  import t07_pkg::*;

  localparam int CntW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CntW-1:0] Last = CntW'(CLK_HZ - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = en && !clr && (cnt_q == Last);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/t07_fsm_game.sv
// Game-state controller: MENU/PLAY/LOST/WON sequencing, module count, countdown and lives.
module t07_fsm_game #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int TIME_LIMIT = 300,
  parameter int MAX_LIVES  = 3,
  parameter int MAX_MODS   = 5
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       strobe,
  input  logic [5:0] button,
  input  logic       game_clear,
  input  logic       strike_edge,
  output logic [2:0] game_state_out,
  output logic [2:0] mod_num,
  output logic [1:0] lives,
  output logic [8:0] time_left,
  output logic       sec_tick
);
  import t07_pkg::*;

  localparam logic [8:0] TimeInit = 9'(TIME_LIMIT);
  localparam logic [1:0] LivesInit = 2'(MAX_LIVES);
  localparam logic [2:0] ModsMax = 3'(MAX_MODS);

  game_state_t state_q, state_d;
  logic [2:0]  mod_q, mod_d;
  logic [1:0]  lives_q, lives_d;
  logic [8:0]  time_q, time_d;
  logic        tick_q, tick_d;
  logic        tick;
  logic        press;
  logic        in_play;

  assign in_play = (state_q == PLAY);

  // Held clear outside PLAY, so the first tick lands CLK_HZ cycles after entry.
  t07_sec_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .clk (clk),
    .nrst(nrst),
    .en  (in_play),
    .clr (!in_play),
    .tick(tick)
  );

  always_comb begin
    state_d = state_q;
    mod_d   = mod_q;
    lives_d = lives_q;
    time_d  = time_q;
    tick_d  = 1'b0;
    press   = is_press(strobe, button);
    case (state_q)
      MENU: begin
        if (press) begin
          if (button == BTN_UP && mod_q < ModsMax) mod_d = mod_q + 3'd1;
          if (button == BTN_DOWN && mod_q > 3'd1) mod_d = mod_q - 3'd1;
          if (button == BTN_SELECT) begin
            state_d = PLAY;
            lives_d = LivesInit;
            time_d  = TimeInit;
          end
        end
      end
      PLAY: begin
        if (game_clear) begin
          state_d = WON;
        end else begin
          if (strike_edge && lives_q != 2'd0) lives_d = lives_q - 2'd1;
          if (tick && time_q != 9'd0) begin
            time_d = time_q - 9'd1;
            tick_d = 1'b1;
          end
          if ((strike_edge && lives_q <= 2'd1) || (tick && time_q <= 9'd1)) state_d = LOST;
        end
      end
      LOST, WON: begin
        if (press && button == BTN_SELECT) state_d = MENU;
      end
      default: state_d = MENU;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= MENU;
      mod_q   <= 3'd1;
      lives_q <= LivesInit;
      time_q  <= TimeInit;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mod_q   <= mod_d;
      lives_q <= lives_d;
      time_q  <= time_d;
      tick_q  <= tick_d;
    end
  end

  assign game_state_out = state_q;
  assign mod_num        = mod_q;
  assign lives          = lives_q;
  assign time_left      = time_q;
  assign sec_tick       = tick_q;

endmodule

// File: tb/tb_t07_fsm_game.sv
// Bench for t07_fsm_game: directed game scenarios plus random play against a behavioural model.
module tb_t07_fsm_game;

  localparam int ClkHz = 10;
  localparam int TimeLimit = 4;
  localparam int MaxLives = 3;
  localparam int MaxMods = 5;

  logic       tb_clk = 1'b0;
  logic       nrst = 1'b0;
  logic       strobe = 1'b0;
  logic [5:0] button = 6'd0;
  logic       game_clear = 1'b0;
  logic       strike_edge = 1'b0;
  logic [2:0] game_state_out;
  logic [2:0] mod_num;
  logic [1:0] lives;
  logic [8:0] time_left;
  logic       sec_tick;

  always #5 tb_clk = ~tb_clk;

  t07_fsm_game #(
    .CLK_HZ    (ClkHz),
    .TIME_LIMIT(TimeLimit),
    .MAX_LIVES (MaxLives),
    .MAX_MODS  (MaxMods)
  ) dut (
    .clk           (tb_clk),
    .nrst          (nrst),
    .strobe        (strobe),
    .button        (button),
    .game_clear    (game_clear),
    .strike_edge   (strike_edge),
    .game_state_out(game_state_out),
    .mod_num       (mod_num),
    .lives         (lives),
    .time_left     (time_left),
    .sec_tick      (sec_tick)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  int tick_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: game phase as 0..3, play time measured in cycles since entering PLAY.
  int m_state, m_mods, m_lives, m_time, m_tick, m_play_cycles;

  task automatic model_reset();
    m_state = 0;
    m_mods = 1;
    m_lives = MaxLives;
    m_time = TimeLimit;
    m_tick = 0;
    m_play_cycles = 0;
  endtask

  always @(posedge tb_clk or negedge nrst) begin
    if (!nrst) begin
      model_reset();
    end else begin
      automatic bit pressed = strobe && ($countones(button) == 1);
      automatic bit sec_due;
      m_tick = 0;
      if (m_state == 0) begin
        if (pressed && button == 6'b000010 && m_mods < MaxMods) m_mods = m_mods + 1;
        if (pressed && button == 6'b001000 && m_mods > 1) m_mods = m_mods - 1;
        if (pressed && button == 6'b000001) begin
          m_state = 1;
          m_lives = MaxLives;
          m_time = TimeLimit;
          m_play_cycles = 0;
        end
      end else if (m_state == 1) begin
        m_play_cycles = m_play_cycles + 1;
        sec_due = (m_play_cycles % ClkHz) == 0;
        if (game_clear) begin
          m_state = 3;
        end else begin
          if (strike_edge && m_lives > 0) m_lives = m_lives - 1;
          if (sec_due && m_time > 0) begin
            m_time = m_time - 1;
            m_tick = 1;
          end
          if (m_lives == 0 || m_time == 0) m_state = 2;
        end
      end else begin
        if (pressed && button == 6'b000001) m_state = 0;
      end
    end
  end

  always @(negedge tb_clk) begin
    if (cmp_en) begin
      chk("state", 32'(game_state_out), 32'(m_state));
      chk("mod_num", 32'(mod_num), 32'(m_mods));
      chk("lives", 32'(lives), 32'(m_lives));
      chk("time_left", 32'(time_left), 32'(m_time));
      chk("sec_tick", 32'(sec_tick), 32'(m_tick));
    end
    if (sec_tick === 1'b1) tick_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge tb_clk);
  endtask

  task automatic press(input logic [5:0] b);
    @(negedge tb_clk);
    strobe = 1'b1;
    button = b;
    @(negedge tb_clk);
    strobe = 1'b0;
    button = 6'd0;
  endtask

  task automatic strike();
    @(negedge tb_clk);
    strike_edge = 1'b1;
    @(negedge tb_clk);
    strike_edge = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int st, input int md, input int lv, input int tl);
    chk({tag, "_state"}, 32'(game_state_out), 32'(st));
    chk({tag, "_mod"}, 32'(mod_num), 32'(md));
    chk({tag, "_lives"}, 32'(lives), 32'(lv));
    chk({tag, "_time"}, 32'(time_left), 32'(tl));
  endtask

  initial begin
    // Test 1: reset values
    idle(3);
    chk_all("rst", 0, 1, 3, 4);
    chk("rst_tick", 32'(sec_tick), 32'd0);
    nrst = 1'b1;
    cmp_en = 1'b1;
    idle(2);
    chk_all("rel", 0, 1, 3, 4);

    // Test 2: mod_num saturation and malformed press
    repeat (6) press(6'b000010);
    chk("up_sat", 32'(mod_num), 32'd5);
    repeat (5) press(6'b001000);
    chk("down_sat", 32'(mod_num), 32'd1);
    press(6'b000011);
    chk("bad_code", 32'(mod_num), 32'd1);
    press(6'b000100);
    chk("right_ignored", 32'(mod_num), 32'd1);

    // Test 3: timer runs out
    press(6'b000001);
    tick_cnt = 0;
    chk_all("entry", 1, 1, 3, 4);
    idle(9);
    chk("t9", 32'(time_left), 32'd4);
    idle(1);
    chk("t10", 32'(time_left), 32'd3);
    chk("t10_tick", 32'(sec_tick), 32'd1);
    idle(1);
    chk("t11_tick", 32'(sec_tick), 32'd0);
    idle(9);
    chk("t20", 32'(time_left), 32'd2);
    idle(10);
    chk("t30", 32'(time_left), 32'd1);
    idle(10);
    chk_all("t40", 2, 1, 3, 0);
    idle(15);
    chk("tick_count", 32'(tick_cnt), 32'd4);
    chk_all("lost_frozen", 2, 1, 3, 0);

    // Test 4: three strikes
    press(6'b000001);
    chk("lost_to_menu", 32'(game_state_out), 32'd0);
    press(6'b000010);
    press(6'b000010);
    press(6'b000001);
    chk_all("play2", 1, 3, 3, 4);
    strike();
    chk("strike1", 32'(lives), 32'd2);
    strike();
    chk("strike2", 32'(lives), 32'd1);
    strike();
    chk_all("strike3", 2, 3, 0, 4);
    press(6'b000001);
    chk_all("menu_keep_mod", 0, 3, 0, 4);

    // Test 5: clear beats a fatal strike on the same edge
    press(6'b000001);
    strike();
    strike();
    chk("lives_one", 32'(lives), 32'd1);
    @(negedge tb_clk);
    game_clear = 1'b1;
    strike_edge = 1'b1;
    @(negedge tb_clk);
    game_clear = 1'b0;
    strike_edge = 1'b0;
    chk_all("won", 3, 3, 1, 4);
    strike();
    strike();
    idle(25);
    chk_all("won_frozen", 3, 3, 1, 4);
    press(6'b000001);
    chk("won_to_menu", 32'(game_state_out), 32'd0);

    // Test 6: asynchronous reset mid-game
    press(6'b000010);
    press(6'b000001);
    strike();
    idle(19);
    chk_all("pre_rst", 1, 4, 2, 2);
    @(posedge tb_clk);
    #3;
    nrst = 1'b0;
    #1;
    chk_all("async_rst", 0, 1, 3, 4);
    chk("async_rst_tick", 32'(sec_tick), 32'd0);
    @(negedge tb_clk);
    nrst = 1'b1;

    // Random play against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge tb_clk);
      begin
        automatic int r = int'($urandom % 8);
        strobe = ($urandom % 3) == 0;
        if (r < 6) button = 6'(1 << r);
        else button = 6'($urandom % 64);
        strike_edge = ($urandom % 10) == 0;
        game_clear = ($urandom % 30) == 0;
      end
    end
    @(negedge tb_clk);
    strobe = 1'b0;
    button = 6'd0;
    strike_edge = 1'b0;
    game_clear = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/t07_fsm_game.md
# t07_fsm_game

Top-level game-state controller for the team_07 bomb game. Runs the MENU/PLAY/LOST/WON sequence and configures the module count in MENU. During PLAY it owns the countdown timer and the strike/lives counter. Its `game_state_out` and `mod_num` drive `t07_fsm_playing`, and it consumes that block's `game_clear`.

## Interface
Parameters:
- `CLK_HZ`, 12_000_000: clock frequency; one timer tick every `CLK_HZ` cycles.
- `TIME_LIMIT`, 300: countdown start value in seconds, 1..511.
- `MAX_LIVES`, 3: lives at game start, 1..3.
- `MAX_MODS`, 5: upper bound for `mod_num`, 1..7.

Ports:
- `clk`  in  1  system clock.
- `nrst`  in  1  asynchronous, active-low reset.
- `strobe`  in  1  one-cycle pulse marking `button` as valid (debounced).
- `button`  in  6  one-hot button code: SELECT=000001, UP=000010, RIGHT=000100, DOWN=001000, LEFT=010000, BACK=100000.
- `game_clear`  in  1  all modules cleared (from `t07_fsm_playing`).
- `strike_edge`  in  1  one-cycle pulse on a wrong submodule action.
- `game_state_out`  out  3  MENU=0, PLAY=1, LOST=2, WON=3.
- `mod_num`  out  3  number of modules for this game.
- `lives`  out  2  remaining lives.
- `time_left`  out  9  remaining seconds.
- `sec_tick`  out  1  one-cycle pulse on each timer decrement (for display refresh).

## Operation
- **Press definition:** a press is a cycle with `strobe`=1 and `button` equal to exactly one code. Any other `button` value under `strobe`, including zero, is ignored.
- **MENU:**
  - UP: `mod_num`+1, saturating at `MAX_MODS`.
  - DOWN: `mod_num`-1, saturating at 1.
  - SELECT: go to PLAY. Load `time_left`=`TIME_LIMIT` and `lives`=`MAX_LIVES`; clear the prescaler.
  - Other buttons and `strike_edge` are ignored. `time_left` and `lives` hold.
- **PLAY:**
  - All buttons are ignored; they belong to `t07_fsm_playing` and the submodules.
  - The prescaler runs. On each tick, `time_left`-1.
  - A tick with `time_left`==1 gives `time_left`=0 and goes to LOST.
  - `strike_edge`: `lives`-1. If `lives` was 1, it becomes 0 and the state goes to LOST.
- **Simultaneous events in PLAY:** `game_clear` has highest priority and goes to WON; `lives` and `time_left` hold on that edge. A strike and a tick on the same edge are both applied. LOST is taken if either one reaches zero.
- **LOST/WON:**
  - Prescaler stopped; `lives` and `time_left` frozen for display.
  - SELECT returns to MENU. `mod_num` is retained.
  - `game_clear` and `strike_edge` are ignored.
- **Arithmetic:** all counters saturate. `lives` and `time_left` never wrap below 0.
- **Encoding:** state codes 4..7 are unreachable; the next state from any of them is MENU.

## Timing
- **Registers:** all outputs are registered. A press or event sampled on edge N is reflected after edge N.
- **Reset values** (async; also applies mid-game):
  - `game_state_out`=MENU
  - `mod_num`=1
  - `lives`=`MAX_LIVES`
  - `time_left`=`TIME_LIMIT`
  - `sec_tick`=0
  - prescaler=0
- **Timer:**
  - The first decrement comes exactly `CLK_HZ` cycles after the edge that entered PLAY. Later decrements follow every `CLK_HZ` cycles.
  - `sec_tick` is high for the cycle after each decrement edge.
- **Pulse inputs:** `strike_edge` and `strobe` are single-cycle. Holding either high for k cycles counts as k events; no edge detection is done internally.
- **`game_clear`:** level input, acted on at the first PLAY edge where it is high.

## Structure
- **Shared package `t07_pkg`:**
  - `game_state_t` (MENU/PLAY/LOST/WON, 3 bits), shared with `t07_fsm_playing`.
  - `playing_state_t`.
  - Button code constants (`BTN_SELECT` … `BTN_BACK`, `BTN_NONE`).
- **Sub-module `t07_sec_prescaler`:**
  - Parameter `CLK_HZ`.
  - Inputs `en` and `clr`; output `tick`.
  - Counter width `$clog2(CLK_HZ)`.
- **FSM:** one `always_ff` block with asynchronous `nrst`, plus a combinational next-state block.

## Test plan
The bench uses `CLK_HZ`=10, `TIME_LIMIT`=4, `MAX_LIVES`=3, `MAX_MODS`=5.
1. Reset, then release: state MENU, `mod_num`=1, `lives`=3, `time_left`=4, `sec_tick`=0.
2. MENU: 6× UP gives `mod_num`=5 (saturated). Then 5× DOWN gives `mod_num`=1. UP with `button`=000011 under `strobe` leaves `mod_num` unchanged.
3. SELECT then idle: state PLAY. `time_left` reads 3, 2, 1 at 10, 20, 30 cycles after entry. At 40 cycles, `time_left`=0 and the state is LOST. `sec_tick` pulses 4 times.
4. PLAY with 3 `strike_edge` pulses: `lives` 2, 1, 0, and state LOST after the third. Then SELECT: MENU, with `mod_num` still at its pre-game value.
5. PLAY with `lives`=1, `game_clear`=1 and `strike_edge`=1 on the same edge: state WON, `lives`=1. Later strikes and ticks change nothing.
6. `nrst` low mid-PLAY (`time_left`=2, `lives`=2, `mod_num`=4): immediately MENU, `mod_num`=1, `lives`=3, `time_left`=4, with no clock edge needed.
